// File: rtl/ram_port_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// ram_port_arbiter_pkg
// Shared definitions for the RAM port arbiter: arbiter state encoding,
// master id constants and the RAM address width.
// ---------------------------------------------------------------------------
package ram_port_arbiter_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_LOCK = 1'b1
  } arb_state_t;

  localparam logic MID_IBUS = 1'b0;
  localparam logic MID_DBUS = 1'b1;

  localparam int RAM_AW = 24;

endpackage

// File: rtl/ram_port_arbiter_select.sv
// ---------------------------------------------------------------------------
// ram_arb_select
// Combinational grant selection used while the arbiter holds no lock.
//
// Ports:
//   req0, req1   : request from ibus (m0) and dbus (m1)
//   last_id      : id of the master that completed most recently
//   consec_cnt   : consecutive dbus completions while ibus was waiting
//   grant_valid  : some master is granted
//   grant_id     : id of the granted master
// Parameters:
//   RR_MODE      : 0 = fixed priority (dbus first), 1 = round-robin
//   MAX_CONSEC   : dbus win limit while ibus waits (fixed mode only)
// ---------------------------------------------------------------------------
module ram_arb_select
  import ram_port_arbiter_pkg::*;
#(
  parameter int RR_MODE    = 0,
  parameter int MAX_CONSEC = 4
) (
  input  logic       req0,
  input  logic       req1,
  input  logic       last_id,
  input  logic [3:0] consec_cnt,
  output logic       grant_valid,
  output logic       grant_id
);

  localparam logic [3:0] MAX_C = 4'(MAX_CONSEC);

  // With both masters requesting, round-robin hands the port to whoever did
  // not complete last; fixed mode favours dbus until ibus has been passed
  // over MAX_CONSEC times in a row.
  always_comb begin
    grant_valid = 1'b0;
    grant_id    = MID_IBUS;
    if (req0 && req1) begin
      grant_valid = 1'b1;
      if (RR_MODE != 0) begin
        grant_id = ~last_id;
      end else if (consec_cnt == MAX_C) begin
        grant_id = MID_IBUS;
      end else begin
        grant_id = MID_DBUS;
      end
    end else if (req0) begin
      grant_valid = 1'b1;
      grant_id    = MID_IBUS;
    end else if (req1) begin
      grant_valid = 1'b1;
      grant_id    = MID_DBUS;
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// ---------------------------------------------------------------------------
// ram_port_arbiter
// Shares the single RAM slave port between the CPU instruction-fetch master
// (ibus, m0) and the data master (dbus, m1). Grants are combinational in the
// request cycle, held across RAM stall cycles, and ibus starvation is bounded.
//
// Ports:
//   clk, rst_n                  : clock, asynchronous active-low reset
//   m0_* / m1_*                 : ibus / dbus master ports (address, byte
//                                 enables, read, write, write data in;
//                                 read data, stall out)
//   ram_address, ram_data_enable,
//   ram_data_i, ram_rd, ram_wr  : request forwarded from the granted master
//   ram_data_o, ram_stall       : RAM read data and stall
// ---------------------------------------------------------------------------
module ram_port_arbiter
  import ram_port_arbiter_pkg::*;
#(
  parameter int RR_MODE    = 0,
  parameter int MAX_CONSEC = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       m0_address,
  input  logic [3:0]        m0_byteenable,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [31:0]       m0_wrdata,
  output logic [31:0]       m0_rddata,
  output logic              m0_stall,
  input  logic [31:0]       m1_address,
  input  logic [3:0]        m1_byteenable,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [31:0]       m1_wrdata,
  output logic [31:0]       m1_rddata,
  output logic              m1_stall,
  output logic [RAM_AW-1:0] ram_address,
  output logic [3:0]        ram_data_enable,
  output logic [31:0]       ram_data_i,
  output logic              ram_rd,
  output logic              ram_wr,
  input  logic [31:0]       ram_data_o,
  input  logic              ram_stall
);

  localparam logic [3:0] MAX_C = 4'(MAX_CONSEC);

  arb_state_t state, state_nxt;
  logic       lock_id, lock_id_nxt;
  logic       last_id;
  logic [3:0] consec_cnt;

  logic       req0, req1;
  logic       sel_valid, sel_id;
  logic       grant_valid, grant_id;
  logic       grant_req;
  logic       complete;
  logic       grant0, grant1;

  // The RAM only decodes the low address bits.
  logic       unused_addr_hi;
  assign unused_addr_hi = ^{m0_address[31:RAM_AW], m1_address[31:RAM_AW]};

  assign req0 = m0_read | m0_write;
  assign req1 = m1_read | m1_write;

  ram_arb_select #(
    .RR_MODE    (RR_MODE),
    .MAX_CONSEC (MAX_CONSEC)
  ) u_select (
    .req0        (req0),
    .req1        (req1),
    .last_id     (last_id),
    .consec_cnt  (consec_cnt),
    .grant_valid (sel_valid),
    .grant_id    (sel_id)
  );

  // A held lock overrides fresh arbitration so a stalled access keeps the port.
  always_comb begin
    grant_valid = sel_valid;
    grant_id    = sel_id;
    if (state == ST_LOCK) begin
      grant_valid = 1'b1;
      grant_id    = lock_id;
    end
  end

  assign grant_req = (grant_id == MID_DBUS) ? req1 : req0;
  assign complete  = grant_valid & grant_req & ~ram_stall;
  assign grant0    = grant_valid & (grant_id == MID_IBUS);
  assign grant1    = grant_valid & (grant_id == MID_DBUS);

  // Lock on a stalled access; release on completion or when the locked
  // master abandons its request.
  always_comb begin
    state_nxt   = state;
    lock_id_nxt = lock_id;
    case (state)
      ST_IDLE: begin
        if (grant_valid && grant_req && ram_stall) begin
          state_nxt   = ST_LOCK;
          lock_id_nxt = grant_id;
        end
      end
      ST_LOCK: begin
        if (!grant_req || !ram_stall) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      lock_id <= MID_IBUS;
    end else begin
      state   <= state_nxt;
      lock_id <= lock_id_nxt;
    end
  end

  // consec_cnt only grows while ibus is actually waiting behind dbus; any
  // ibus completion or an uncontested dbus completion starts it over.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_id    <= MID_IBUS;
      consec_cnt <= 4'd0;
    end else if (complete) begin
      last_id <= grant_id;
      if (grant_id == MID_DBUS && req0) begin
        if (consec_cnt != MAX_C) begin
          consec_cnt <= consec_cnt + 4'd1;
        end
      end else begin
        consec_cnt <= 4'd0;
      end
    end
  end

  // Datapath: RAM side follows the granted master; a waiting loser sees stall.
  always_comb begin
    ram_address     = '0;
    ram_data_enable = '0;
    ram_data_i      = '0;
    ram_rd          = 1'b0;
    ram_wr          = 1'b0;
    m0_rddata       = '0;
    m1_rddata       = '0;
    m0_stall        = req0;
    m1_stall        = req1;
    if (grant0) begin
      ram_address     = m0_address[RAM_AW-1:0];
      ram_data_enable = m0_byteenable;
      ram_data_i      = m0_wrdata;
      ram_rd          = m0_read;
      ram_wr          = m0_write;
      m0_rddata       = ram_data_o;
      m0_stall        = ram_stall;
    end else if (grant1) begin
      ram_address     = m1_address[RAM_AW-1:0];
      ram_data_enable = m1_byteenable;
      ram_data_i      = m1_wrdata;
      ram_rd          = m1_read;
      ram_wr          = m1_write;
      m1_rddata       = ram_data_o;
      m1_stall        = ram_stall;
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ram_port_arbiter
// Scoreboard bench for ram_port_arbiter. Two instances share the same
// stimulus: one in fixed-priority mode, one in round-robin mode. Each cycle
// the stimulus process predicts both instances' outputs from a behavioural
// model and queues them; a monitor pops and compares on the falling edge.
// ---------------------------------------------------------------------------
module tb_ram_port_arbiter;

  localparam int MAXC = 4;

  typedef struct packed {
    logic [23:0] addr;
    logic [3:0]  be;
    logic [31:0] wd;
    logic        rd;
    logic        wr;
    logic [31:0] rd0;
    logic        s0;
    logic [31:0] rd1;
    logic        s1;
  } obs_t;

  typedef struct {
    bit locked;
    bit lock_id;
    bit last_id;
    int consec;
  } mstate_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] m0_address = '0, m1_address = '0;
  logic [3:0]  m0_byteenable = '0, m1_byteenable = '0;
  logic        m0_read = 1'b0, m0_write = 1'b0, m1_read = 1'b0, m1_write = 1'b0;
  logic [31:0] m0_wrdata = '0, m1_wrdata = '0;
  logic [31:0] ram_data_o = '0;
  logic        ram_stall = 1'b0;

  logic [31:0] f_m0_rddata, f_m1_rddata, r_m0_rddata, r_m1_rddata;
  logic        f_m0_stall, f_m1_stall, r_m0_stall, r_m1_stall;
  logic [23:0] f_ram_address, r_ram_address;
  logic [3:0]  f_ram_data_enable, r_ram_data_enable;
  logic [31:0] f_ram_data_i, r_ram_data_i;
  logic        f_ram_rd, f_ram_wr, r_ram_rd, r_ram_wr;

  obs_t    q_fix[$];
  obs_t    q_rr[$];
  mstate_t st_fix, st_rr;
  int      checks = 0;
  int      passed = 0;
  int      cycle  = 0;

  always #5 clk = ~clk;

  ram_port_arbiter #(.RR_MODE(0), .MAX_CONSEC(MAXC)) u_fix (
    .clk(clk), .rst_n(rst_n),
    .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
    .m0_write(m0_write), .m0_wrdata(m0_wrdata), .m0_rddata(f_m0_rddata), .m0_stall(f_m0_stall),
    .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
    .m1_write(m1_write), .m1_wrdata(m1_wrdata), .m1_rddata(f_m1_rddata), .m1_stall(f_m1_stall),
    .ram_address(f_ram_address), .ram_data_enable(f_ram_data_enable), .ram_data_i(f_ram_data_i),
    .ram_rd(f_ram_rd), .ram_wr(f_ram_wr), .ram_data_o(ram_data_o), .ram_stall(ram_stall)
  );

  ram_port_arbiter #(.RR_MODE(1), .MAX_CONSEC(MAXC)) u_rr (
    .clk(clk), .rst_n(rst_n),
    .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
    .m0_write(m0_write), .m0_wrdata(m0_wrdata), .m0_rddata(r_m0_rddata), .m0_stall(r_m0_stall),
    .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
    .m1_write(m1_write), .m1_wrdata(m1_wrdata), .m1_rddata(r_m1_rddata), .m1_stall(r_m1_stall),
    .ram_address(r_ram_address), .ram_data_enable(r_ram_data_enable), .ram_data_i(r_ram_data_i),
    .ram_rd(r_ram_rd), .ram_wr(r_ram_wr), .ram_data_o(ram_data_o), .ram_stall(ram_stall)
  );

  obs_t act_fix, act_rr;
  always_comb begin
    act_fix = {f_ram_address, f_ram_data_enable, f_ram_data_i, f_ram_rd, f_ram_wr,
               f_m0_rddata, f_m0_stall, f_m1_rddata, f_m1_stall};
    act_rr  = {r_ram_address, r_ram_data_enable, r_ram_data_i, r_ram_rd, r_ram_wr,
               r_m0_rddata, r_m0_stall, r_m1_rddata, r_m1_stall};
  end

  // Who owns the port this cycle, straight from the arbitration rules.
  function automatic bit model_grant(input bit rr, input mstate_t st, output bit gid);
    bit r0 = m0_read | m0_write;
    bit r1 = m1_read | m1_write;
    gid = 1'b0;
    if (st.locked) begin
      gid = st.lock_id;
      return 1'b1;
    end
    if (r0 && r1) begin
      if (rr) gid = !st.last_id;
      else    gid = (st.consec == MAXC) ? 1'b0 : 1'b1;
      return 1'b1;
    end
    if (r1) gid = 1'b1;
    return r0 | r1;
  endfunction

  function automatic obs_t model_out(input bit gv, input bit gid);
    obs_t o = '0;
    o.s0 = m0_read | m0_write;
    o.s1 = m1_read | m1_write;
    if (gv && !gid) begin
      o.addr = m0_address[23:0]; o.be = m0_byteenable; o.wd = m0_wrdata;
      o.rd = m0_read; o.wr = m0_write; o.rd0 = ram_data_o; o.s0 = ram_stall;
    end else if (gv && gid) begin
      o.addr = m1_address[23:0]; o.be = m1_byteenable; o.wd = m1_wrdata;
      o.rd = m1_read; o.wr = m1_write; o.rd1 = ram_data_o; o.s1 = ram_stall;
    end
    return o;
  endfunction

  function automatic mstate_t model_next(input mstate_t st, input bit gv, input bit gid);
    mstate_t n = st;
    bit r0 = m0_read | m0_write;
    bit r1 = m1_read | m1_write;
    bit rg = gid ? r1 : r0;
    if (st.locked) begin
      if (!rg || !ram_stall) n.locked = 1'b0;
    end else if (gv && rg && ram_stall) begin
      n.locked  = 1'b1;
      n.lock_id = gid;
    end
    if (gv && rg && !ram_stall) begin
      n.last_id = gid;
      if (gid && r0) n.consec = (st.consec + 1 > MAXC) ? MAXC : st.consec + 1;
      else           n.consec = 0;
    end
    return n;
  endfunction

  task automatic predictCycle();
    bit gv, gid;
    gv = model_grant(1'b0, st_fix, gid);
    q_fix.push_back(model_out(gv, gid));
    st_fix = model_next(st_fix, gv, gid);
    gv = model_grant(1'b1, st_rr, gid);
    q_rr.push_back(model_out(gv, gid));
    st_rr = model_next(st_rr, gv, gid);
  endtask

  // Drive one cycle of inputs just after the rising edge. With do_reset the
  // reset is pulsed mid-cycle, after the inputs settle, and held until the
  // falling edge so the asynchronous drop is observed by the monitor.
  task automatic applyStimulus(input bit do_reset, input bit rd0, input bit wr0,
                               input bit rd1, input bit wr1, input bit stall,
                               input logic [31:0] a0);
    @(posedge clk);
    #1;
    cycle++;
    m0_address = a0;           m1_address = $urandom;
    m0_byteenable = 4'($urandom); m1_byteenable = 4'($urandom);
    m0_wrdata = $urandom;      m1_wrdata = $urandom;
    m0_read = rd0; m0_write = wr0; m1_read = rd1; m1_write = wr1;
    ram_stall = stall;
    ram_data_o = $urandom;
    if (do_reset) begin
      #1;
      rst_n = 1'b0;
      st_fix = '{default: 0};
      st_rr  = '{default: 0};
    end
    predictCycle();
    if (do_reset) begin
      @(negedge clk);
      #1;
      rst_n = 1'b1;
    end
  endtask

  task automatic checkOutput(input string name, input obs_t exp_o, input obs_t act_o);
    checks++;
    if (act_o !== exp_o) begin
      $display("[TB] FAIL %s cycle %0d: got addr=%h be=%h wd=%h rd=%b wr=%b rd0=%h s0=%b rd1=%h s1=%b ; expected addr=%h be=%h wd=%h rd=%b wr=%b rd0=%h s0=%b rd1=%h s1=%b",
               name, cycle, act_o.addr, act_o.be, act_o.wd, act_o.rd, act_o.wr, act_o.rd0,
               act_o.s0, act_o.rd1, act_o.s1, exp_o.addr, exp_o.be, exp_o.wd, exp_o.rd,
               exp_o.wr, exp_o.rd0, exp_o.s0, exp_o.rd1, exp_o.s1);
    end else begin
      passed++;
    end
  endtask

  // Monitor: compare whatever the stimulus has predicted for this cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (q_fix.size() > 0) checkOutput("fixed", q_fix.pop_front(), act_fix);
      if (q_rr.size() > 0)  checkOutput("rr", q_rr.pop_front(), act_rr);
    end
  end

  initial begin
    st_fix = '{default: 0};
    st_rr  = '{default: 0};

    // Reset state with no requests: every output zero.
    applyStimulus(1, 0, 0, 0, 0, 0, $urandom);
    applyStimulus(0, 0, 0, 0, 0, 0, $urandom);

    // Lone ibus read at 0x1000.
    applyStimulus(0, 1, 0, 0, 0, 0, 32'h0000_1000);

    // Both reading: dbus wins MAXC times, then ibus, then dbus again.
    for (int i = 0; i < MAXC + 3; i++) applyStimulus(0, 1, 0, 1, 0, 0, $urandom);

    // ibus locked by a 3-cycle stall while dbus waits, then released.
    applyStimulus(0, 1, 0, 0, 0, 1, $urandom);
    applyStimulus(0, 1, 0, 1, 0, 1, $urandom);
    applyStimulus(0, 1, 0, 1, 0, 1, $urandom);
    applyStimulus(0, 1, 0, 1, 0, 0, $urandom);
    applyStimulus(0, 0, 0, 1, 0, 0, $urandom);

    // dbus write locked, then abandoned while stalled; ibus takes over.
    applyStimulus(0, 0, 0, 0, 1, 1, $urandom);
    applyStimulus(0, 1, 0, 0, 0, 1, $urandom);
    applyStimulus(0, 1, 0, 0, 0, 0, $urandom);

    // Reset arriving while ibus holds a lock.
    applyStimulus(0, 1, 0, 0, 0, 1, $urandom);
    applyStimulus(1, 1, 0, 1, 0, 1, $urandom);
    applyStimulus(0, 1, 0, 1, 0, 0, $urandom);
    applyStimulus(0, 1, 0, 1, 0, 0, $urandom);

    // Random traffic, stalls and occasional resets.
    for (int i = 0; i < 600; i++) begin
      applyStimulus(($urandom_range(0, 59) == 0),
                    ($urandom_range(0, 9) < 6), ($urandom_range(0, 9) < 2),
                    ($urandom_range(0, 9) < 6), ($urandom_range(0, 9) < 2),
                    ($urandom_range(0, 9) < 4), $urandom);
    end

    @(negedge clk);
    @(negedge clk);
    checks++;
    if (q_fix.size() != 0 || q_rr.size() != 0)
      $display("[TB] FAIL drain: pending fixed=%0d rr=%0d, expected 0", q_fix.size(), q_rr.size());
    else
      passed++;

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Shares the single external RAM slave port between the CPU instruction-fetch master (ibus, m0) and the data master (dbus, m1).
- Sits between the two CPU bus masters and the RAM controller. The slave side carries the same address, byteenable, rd/wr, data and stall signals as the RAM port of the data-bus decoder.
- Grants access combinationally in the request cycle, so an unstalled access adds zero latency.
- Holds a grant across slave stall cycles, and bounds starvation of the losing master.

Parameters:
- RR_MODE, 0: 0 = fixed priority, dbus first. 1 = round-robin between the two masters.
- MAX_CONSEC, 4: in fixed mode, the maximum number of consecutive completed dbus transfers while ibus is waiting. After that, ibus wins the next arbitration. Range 1..15.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- m0_address  in  32  ibus address
- m0_byteenable  in  4  ibus byte enables
- m0_read  in  1  ibus read request
- m0_write  in  1  ibus write request
- m0_wrdata  in  32  ibus write data
- m0_rddata  out  32  ibus read data
- m0_stall  out  1  ibus stall
- m1_address, m1_byteenable, m1_read, m1_write, m1_wrdata, m1_rddata, m1_stall: same widths and meanings for dbus
- ram_address  out  24  equals the granted master's address[23:0]
- ram_data_enable  out  4  granted master's byte enables
- ram_data_i  out  32  granted master's write data
- ram_rd  out  1  granted master's read
- ram_wr  out  1  granted master's write
- ram_data_o  in  32  RAM read data
- ram_stall  in  1  RAM stall

Behaviour:
- Request definitions:
  - req_m = m_read | m_write.
  - A transfer completes in any cycle where the master is granted, req_m=1 and ram_stall=0.
- State register, 2 states:
  - IDLE: no lock.
  - LOCK: grant is held by lock_id (0 or 1).
- Grant selection in IDLE (combinational):
  - No requests: no grant.
  - Only one request: that master is granted.
  - Both request, RR_MODE=1: grant the master that is not last_id.
  - Both request, RR_MODE=0: grant m1, unless consec_cnt == MAX_CONSEC, in which case grant m0.
- Grant in LOCK: lock_id is granted unconditionally.
- IDLE -> LOCK: when the granted master has req=1 and ram_stall=1. lock_id is set to the granted master.
- LOCK -> IDLE:
  - when the locked master completes (ram_stall=0); or
  - when the locked master drops its request (abandoned access). In that cycle ram_rd=ram_wr=0.
- Datapath muxing:
  - RAM outputs follow the granted master.
  - With no grant, all RAM outputs are 0.
  - Granted master: rddata = ram_data_o, stall = ram_stall.
  - Non-granted master with req=1: stall=1, rddata=0.
  - Non-granted master with req=0: stall=0, rddata=0.
- last_id: updated on every completed transfer to the completing master id.
- consec_cnt (4 bits):
  - +1 on a dbus completion while req_m0=1, saturating at MAX_CONSEC.
  - Cleared on any ibus completion.
  - Cleared when a dbus completion occurs with req_m0=0.
- A master whose read and write are both asserted is treated as a single request. Both are forwarded unchanged to the RAM port; there is no protocol check.
- Reset values:
  - state=IDLE, lock_id=0, last_id=0, consec_cnt=0.
  - With no requests, every output is 0.
- Reset asserted mid-lock: the lock is dropped immediately and asynchronously. Outputs revert to pure combinational arbitration from the IDLE reset state.
- Outputs are combinational from inputs and registered state. There are no registered data paths.

Decomposition:
- Shared bus package:
  - state encodings ST_IDLE and ST_LOCK;
  - master id constants MID_IBUS=0 and MID_DBUS=1;
  - RAM address width constant 24.
- One natural sub-module, ram_arb_select: combinational grant selection. Inputs are req0, req1, RR_MODE, last_id, consec_cnt and MAX_CONSEC; output is grant_valid, grant_id.
- Top-level contents: state and counter registers plus the datapath muxes.

Test Plan:
- Only m0_read with address 0x00001000, no stall -> ram_rd=1, ram_address=0x001000, m0_rddata=ram_data_o, m0_stall=0, state stays IDLE.
- Both read in the same cycle, RR_MODE=0, ram_stall=0 -> m1 granted, m0_stall=1. After 4 dbus completions with m0 waiting, the 5th arbitration grants m0 and consec_cnt returns to 0.
- RR_MODE=1, both requesting continuously, no stall -> grants alternate m1 (last_id=0 after reset), m0, m1, m0.
- m0 granted, ram_stall=1 for 3 cycles while m1 requests -> m0 stays granted through LOCK, m1_stall=1 throughout. On stall release m0 completes and m1 is granted the next cycle.
- Locked m1 write, m1_write drops while ram_stall=1 -> ram_wr=0 in that cycle, state returns to IDLE, a pending m0 is granted the following cycle.
- rst_n asserted low while in LOCK -> immediately state=IDLE and consec_cnt=0. After release, arbitration restarts with last_id=0.
